// File: rtl/capture_reader.sv
// capture_reader: reads 2^SAMPLE_DEPTH bytes out of a capture memory, starting
// at a latched address and wrapping modulo the buffer size, and streams them
// out one at a time over a valid/ready handshake.
//
// Optional build macro CAPTURE_READER_HEADER_EN: when defined, every readout
// is prefixed by two header bytes, 0xA5 followed by the start address
// zero-extended to 8 bits. When undefined, only sample bytes are emitted.
//
// Per-sample sequence is FETCH (read strobe) -> WAIT (memory returns data,
// captured into out_data) -> SEND (held until accepted), so one byte is
// produced every three cycles while the consumer is ready.
module capture_reader #(
  parameter int SAMPLE_DEPTH = 8
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [SAMPLE_DEPTH-1:0] start_addr,
  output logic                    busy,
  output logic                    done,
  output logic [SAMPLE_DEPTH-1:0] mem_addr,
  output logic                    mem_re,
  input  logic [7:0]              mem_data,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Counter value of the final sample of a readout.
  localparam logic [8:0] LAST_CNT = 9'((1 << SAMPLE_DEPTH) - 1);
  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
`ifdef CAPTURE_READER_HEADER_EN
    ,
    S_HDR0  = 3'd5,
    S_HDR1  = 3'd6
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [SAMPLE_DEPTH-1:0] addr_q, addr_d;
  logic [8:0]              cnt_q, cnt_d;
  logic [SAMPLE_DEPTH-1:0] mem_addr_q, mem_addr_d;
  logic                    mem_re_q, mem_re_d;
  logic [7:0]              out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    done_q, done_d;

  logic                    xfer;
  logic [SAMPLE_DEPTH-1:0] addr_inc;

  assign xfer     = out_valid_q & out_ready;
  // Natural overflow of the SAMPLE_DEPTH-bit sum gives the buffer wrap.
  assign addr_inc = addr_q + SAMPLE_DEPTH'(1);

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // Next-state and registered-output logic. Outputs are computed one cycle
  // ahead so that mem_re / done / out_valid are glitch-free flop outputs that
  // line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_re_d    = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    if (state_q != S_IDLE && abort) begin
      // Cancel wins over everything else, including the completion pulse.
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            addr_d = start_addr;
            cnt_d  = 9'd0;
`ifdef CAPTURE_READER_HEADER_EN
            state_d     = S_HDR0;
            out_data_d  = HDR_MAGIC;
            out_valid_d = 1'b1;
`else
            state_d    = S_FETCH;
            mem_re_d   = 1'b1;
            mem_addr_d = start_addr;
`endif
          end
        end

`ifdef CAPTURE_READER_HEADER_EN
        S_HDR0: begin
          if (xfer) begin
            state_d    = S_HDR1;
            out_data_d = 8'(addr_q);
          end
        end

        S_HDR1: begin
          if (xfer) begin
            state_d     = S_FETCH;
            out_valid_d = 1'b0;
            mem_re_d    = 1'b1;
            mem_addr_d  = addr_q;
          end
        end
`endif

        S_FETCH: begin
          state_d = S_WAIT;
        end

        S_WAIT: begin
          // Memory data is valid exactly in this cycle.
          state_d     = S_SEND;
          out_data_d  = mem_data;
          out_valid_d = 1'b1;
        end

        S_SEND: begin
          if (xfer) begin
            out_valid_d = 1'b0;
            if (cnt_q == LAST_CNT) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d    = S_FETCH;
              cnt_d      = cnt_q + 9'd1;
              addr_d     = addr_inc;
              mem_re_d   = 1'b1;
              mem_addr_d = addr_inc;
            end
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
        end

        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= 9'd0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_capture_reader.sv
// Bench for capture_reader: synchronous memory model with mem[i]=i, scoreboard
// queue of expected bytes filled at start time and drained on each transfer.
module tb_capture_reader;

  localparam int SD = 8;
  localparam int N  = 1 << SD;
`ifdef CAPTURE_READER_HEADER_EN
  localparam int HDRS = 2;
`else
  localparam int HDRS = 0;
`endif
  localparam int NB = N + HDRS;

  logic          clk_50mhz = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          out_ready;
  logic [SD-1:0] start_addr;
  logic          busy;
  logic          done;
  logic [SD-1:0] mem_addr;
  logic          mem_re;
  logic [7:0]    mem_data;
  logic [7:0]    out_data;
  logic          out_valid;

  logic [7:0]    mem [N];
  logic [7:0]    exp_q [$];
  int            checks = 0;
  int            errors = 0;

  capture_reader #(.SAMPLE_DEPTH(SD)) dut (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .start_addr(start_addr),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // Synchronous-read capture memory: data one cycle after the strobe.
  always @(posedge clk_50mhz) begin
    if (mem_re) mem_data <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic push_readout(input logic [SD-1:0] a);
`ifdef CAPTURE_READER_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(a));
`endif
    for (int i = 0; i < N; i++) exp_q.push_back(mem[(int'(a) + i) % N]);
  endtask

  task automatic pulse_start(input logic [SD-1:0] a);
    start      = 1'b1;
    start_addr = a;
    push_readout(a);
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #5;
    checks++;
    if ({busy, done, mem_re, out_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000", {busy, done, mem_re, out_valid});
    end
    checks++;
    if (mem_addr !== '0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: mem_addr=%h out_data=%h required 00/00", mem_addr, out_data);
    end
    @(negedge clk_50mhz);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_readout();
    int n = 0, t = 0, last_t = 0;
    logic [7:0] e;
    out_ready = 1'b1;
    pulse_start(8'h00);
`ifndef CAPTURE_READER_HEADER_EN
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL latency_fetch: mem_re=%b mem_addr=%h busy=%b required 1/00/1", mem_re, mem_addr, busy);
    end
    tick();
    checks++;
    if (mem_re !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_wait: mem_re=%b out_valid=%b required 0/0", mem_re, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_valid: out_valid=%b required 1", out_valid);
    end
`endif
    while (n < NB && t < 4000) begin
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (out_data !== e) begin
          errors++;
          $display("FAIL full_byte[%0d]: got %h required %h", n, out_data, e);
        end
        if (n > HDRS) begin
          checks++;
          if (t - last_t != 3) begin
            errors++;
            $display("FAIL full_rate[%0d]: interval %0d required 3", n, t - last_t);
          end
        end
        last_t = t;
        n++;
      end
      tick();
      t++;
    end
    checks++;
    if (n != NB) begin
      errors++;
      $display("FAIL full_count: got %0d required %0d", n, NB);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL full_done: got %b required 1", done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_idle: done=%b busy=%b required 0/0", done, busy);
    end
  endtask

  task automatic test_wrap(input logic [SD-1:0] a, input string tag);
    int n = 0, t = 0;
    logic [7:0] e;
    out_ready = 1'b1;
    pulse_start(a);
    while (n < NB && t < 4000) begin
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (out_data !== e) begin
          errors++;
          $display("FAIL %s_byte[%0d]: got %h required %h", tag, n, out_data, e);
        end
        n++;
      end
      tick();
      t++;
    end
    checks++;
    if (n != NB || done !== 1'b1) begin
      errors++;
      $display("FAIL %s_end: count %0d done %b required %0d/1", tag, n, done, NB);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n = 0, t = 0;
    bit stalled = 0;
    logic [7:0] e, held;
    out_ready = 1'b1;
    pulse_start(8'h40);
    while (n < NB && t < 4000) begin
      if (n == 3 && !stalled && out_valid) begin
        stalled   = 1;
        out_ready = 1'b0;
        held      = out_data;
        for (int i = 0; i < 10; i++) begin
          tick();
          checks++;
          if (out_valid !== 1'b1 || out_data !== held || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL stall[%0d]: valid=%b data=%h re=%b required 1/%h/0", i, out_valid, out_data, mem_re, held);
          end
        end
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (out_data !== e) begin
          errors++;
          $display("FAIL bp_byte[%0d]: got %h required %h", n, out_data, e);
        end
        n++;
      end
      tick();
      t++;
    end
    checks++;
    if (n != NB || done !== 1'b1) begin
      errors++;
      $display("FAIL bp_end: count %0d done %b required %0d/1", n, done, NB);
    end
    tick();
  endtask

  task automatic test_abort();
    int n = 0, t = 0;
    logic [7:0] e;
    out_ready = 1'b1;
    pulse_start(8'h00);
    while (t < 200) begin
      if (n == 4 && out_valid) break;
      if (out_valid && out_ready) begin
        void'(exp_q.pop_front());
        n++;
      end
      tick();
      t++;
    end
    abort     = 1'b1;
    out_ready = 1'b0;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, out_valid, mem_re, done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle: busy/valid/re/done=%b required 0000", {busy, out_valid, mem_re, done});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_nodone[%0d]: done=%b busy=%b required 0/0", i, done, busy);
      end
    end
    exp_q.delete();
    out_ready = 1'b1;
    pulse_start(8'h10);
    n = 0;
    t = 0;
    while (n < 1 && t < 50) begin
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (out_data !== e) begin
          errors++;
          $display("FAIL abort_restart: got %h required %h", out_data, e);
        end
        n++;
      end
      tick();
      t++;
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL abort_restart_timeout: got %0d bytes required 1", n);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int n = 0, t = 0;
    logic [7:0] e;
    out_ready = 1'b1;
    pulse_start(8'h00);
    while (t < 1000) begin
      if (n == 99 + HDRS && out_valid) break;
      if (out_valid && out_ready) begin
        void'(exp_q.pop_front());
        n++;
      end
      tick();
      t++;
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_re, out_valid} !== 4'b0000 || mem_addr !== '0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: busy/done/re/valid=%b addr=%h data=%h required 0000/00/00", {busy, done, mem_re, out_valid}, mem_addr, out_data);
    end
    exp_q.delete();
    @(negedge clk_50mhz);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || mem_re !== 1'b0) begin
        errors++;
        $display("FAIL reset_needs_start[%0d]: busy=%b re=%b required 0/0", i, busy, mem_re);
      end
    end
    // start while busy must be ignored: the sequence must stay the 0x20 one
    pulse_start(8'h20);
    tick();
    start      = 1'b1;
    start_addr = 8'h80;
    tick();
    start = 1'b0;
    n = 0;
    t = 0;
    while (n < NB && t < 4000) begin
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (out_data !== e) begin
          errors++;
          $display("FAIL busy_start_byte[%0d]: got %h required %h", n, out_data, e);
        end
        n++;
      end
      tick();
      t++;
    end
    tick();
    checks++;
    if (busy !== 1'b0 || n != NB) begin
      errors++;
      $display("FAIL busy_start_end: busy=%b count=%0d required 0/%0d", busy, n, NB);
    end
    start      = 1'b1;
    abort      = 1'b1;
    start_addr = 8'h05;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_re !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle: busy=%b re=%b valid=%b required 0/0/0", busy, mem_re, out_valid);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    start      = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    start_addr = '0;
    test_reset();
    test_full_readout();
    test_wrap(8'hFE, "wrap");
`ifdef CAPTURE_READER_HEADER_EN
    test_wrap(8'h37, "header");
`endif
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_reader.md
CAPTURE_READER -- requirements
Module: capture_reader

Interface
REQ-001 Parameter SAMPLE_DEPTH, default 8, SHALL set the log2 of the capture buffer size (2^SAMPLE_DEPTH samples); legal range 1..8.
REQ-002 clk_50mhz  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request a readout when high in IDLE.
REQ-005 abort  input  1  SHALL synchronously cancel a readout in progress.
REQ-006 start_addr  input  SAMPLE_DEPTH  SHALL give the buffer address of the first sample, latched on start.
REQ-007 busy  output  1  SHALL be high in every state except IDLE.
REQ-008 done  output  1  SHALL be a one-cycle completion pulse.
REQ-009 mem_addr  output  SAMPLE_DEPTH  SHALL be the capture memory read address.
REQ-010 mem_re  output  1  SHALL be the memory read strobe.
REQ-011 mem_data  input  8  SHALL carry read data, valid exactly one cycle after the mem_re cycle.
REQ-012 out_data  output  8  SHALL carry the output byte.
REQ-013 out_valid  output  1  SHALL qualify out_data.
REQ-014 out_ready  input  1  SHALL be the downstream accept signal; a transfer occurs on a cycle with out_valid and out_ready both high.

Function
REQ-015 States SHALL be IDLE, FETCH, WAIT, SEND, DONE, plus HDR0 and HDR1 when CAPTURE_READER_HEADER_EN is defined.
REQ-016 IDLE with start=1 and abort=0 SHALL latch start_addr into the address register, clear the 9-bit sample counter, and go to FETCH (HDR0 with the header macro).
REQ-017 FETCH SHALL drive mem_re=1 and mem_addr=address register for exactly one cycle, then go to WAIT.
REQ-018 WAIT SHALL register mem_data into out_data, set out_valid=1, and go to SEND.
REQ-019 SEND SHALL hold out_data and out_valid stable until a transfer occurs, for any number of cycles.
REQ-020 On a SEND transfer with counter = 2^SAMPLE_DEPTH-1, the block SHALL clear out_valid and go to DONE.
REQ-021 On any other SEND transfer, the block SHALL clear out_valid, increment the counter, increment the address modulo 2^SAMPLE_DEPTH, and go to FETCH.
REQ-022 Address wrap: the address after 2^SAMPLE_DEPTH-1 SHALL be 0.
REQ-023 Exactly 2^SAMPLE_DEPTH sample bytes SHALL be emitted per readout, in address order starting at start_addr.
REQ-024 DONE SHALL assert done=1 for one cycle, then go to IDLE.
REQ-025 Steady-state throughput with out_ready held high SHALL be one byte per 3 cycles.
REQ-026 Latency: a start sampled at edge k SHALL produce mem_re high in cycle k+1 and out_valid high from cycle k+3 (no header).
REQ-027 start while busy SHALL be ignored.
REQ-028 abort=1 in any non-IDLE state SHALL return to IDLE at the next edge, with out_valid=0, mem_re=0, and no done pulse.
REQ-029 abort=1 SHALL take priority over start and over the DONE pulse.
REQ-030 mem_re SHALL be 0 outside FETCH.
REQ-031 mem_addr SHALL hold its last value outside FETCH.

Reset
REQ-032 reset low SHALL immediately force state IDLE and busy=0, done=0, mem_re=0, mem_addr=0, out_valid=0, out_data=0, counter=0, address register=0.
REQ-033 Reset mid-readout SHALL discard the readout; the first action after release SHALL require a new start.

Configuration
REQ-034 Macro CAPTURE_READER_HEADER_EN defined: HDR0 SHALL present 0xA5 and HDR1 SHALL present start_addr zero-extended to 8 bits.
REQ-035 Each header byte SHALL use the SEND handshake rules; FETCH follows the HDR1 transfer, giving 2^SAMPLE_DEPTH+2 bytes in total.
REQ-036 Macro undefined: HDR states SHALL be absent and only sample bytes SHALL be emitted.

Verification
REQ-037 Memory preloaded mem[i]=i, start_addr=0, out_ready=1 -> bytes 0x00..0xFF in order, one per 3 cycles, done pulse one cycle after the last transfer.
REQ-038 start_addr=0xFE -> byte sequence 0xFE, 0xFF, 0x00, ..., 0xFD (wrap), 256 bytes total.
REQ-039 out_ready low for 10 cycles during SEND -> out_data and out_valid constant, no mem_re, no byte lost or duplicated.
REQ-040 abort at the 5th byte -> IDLE next cycle, no done pulse; new start with start_addr=0x10 -> 0x10 first.
REQ-041 reset low during the 100th byte -> all outputs 0 immediately; start during busy ignored; start and abort together in IDLE -> stays IDLE.
REQ-042 CAPTURE_READER_HEADER_EN, start_addr=0x37 -> 0xA5, 0x37, then 0x37..0x36, 258 bytes total.
